// File: rtl/id_pipe.sv
// Instruction-decode stage: decodes the IF word, selects forwarded or regfile
// operands, raises the load-use interlock and registers the ID/EX payload behind a valid/ready handshake.
module id_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [4:0]                reg1_addr_o,
  output logic [4:0]                reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD-1:0]        fwd_load_i,
  input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               pc_o,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic                      inv_o,
  output logic                      stall_o,
  output logic [CNT_W-1:0]          inv_cnt_o
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_PREF    = 6'h33;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_SYNC = 6'h0F;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef struct packed {
    logic              hit;
    logic              load;
    logic [DATA_W-1:0] data;
  } fwd_t;

  // Walk oldest to youngest so the lowest-index (youngest) match is the one kept.
  function automatic fwd_t fwd_pick(input logic [4:0]                addr,
                                    input logic [NUM_FWD-1:0]        wreg,
                                    input logic [NUM_FWD-1:0]        load,
                                    input logic [5*NUM_FWD-1:0]      wd,
                                    input logic [DATA_W*NUM_FWD-1:0] wdata);
    fwd_t r;
    r = '0;
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (wreg[k] && (wd[k*5 +: 5] == addr) && (addr != 5'd0)) begin
        r.hit  = 1'b1;
        r.load = load[k];
        r.data = wdata[k*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  logic [5:0]        opc, fn;
  logic [4:0]        rs, rt, rd, sa;
  logic [15:0]       imm16;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [4:0]        dec_wd;
  logic              dec_wreg, dec_inv, dec_rd1, dec_rd2;
  logic [DATA_W-1:0] dec_imm;
  fwd_t              fwd1, fwd2;
  logic [DATA_W-1:0] op1, op2;
  logic              stall, accept;

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d, inv_q, inv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign opc   = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign fn    = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  // Instruction decode; the all-zero word is SLL $0 in encoding but treated as a NOP.
  always_comb begin
    dec_aluop  = OP_NOP;
    dec_alusel = SEL_NOP;
    dec_wd     = 5'd0;
    dec_wreg   = 1'b0;
    dec_inv    = 1'b0;
    dec_rd1    = 1'b0;
    dec_rd2    = 1'b0;
    dec_imm    = '0;
    if (inst_i != 32'd0) begin
      case (opc)
        OPC_SPECIAL: begin
          case (fn)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              dec_wreg   = 1'b1;
              dec_wd     = rd;
              dec_rd1    = 1'b1;
              dec_rd2    = 1'b1;
              dec_alusel = SEL_LOGIC;
              case (fn)
                FN_AND:  dec_aluop = OP_AND;
                FN_OR:   dec_aluop = OP_OR;
                FN_XOR:  dec_aluop = OP_XOR;
                default: dec_aluop = OP_NOR;
              endcase
            end
            FN_SLLV, FN_SRLV, FN_SRAV: begin
              dec_wreg   = 1'b1;
              dec_wd     = rd;
              dec_rd1    = 1'b1;
              dec_rd2    = 1'b1;
              dec_alusel = SEL_SHIFT;
              case (fn)
                FN_SLLV: dec_aluop = OP_SLL;
                FN_SRLV: dec_aluop = OP_SRL;
                default: dec_aluop = OP_SRA;
              endcase
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              dec_wreg   = 1'b1;
              dec_wd     = rd;
              dec_rd2    = 1'b1;
              dec_imm    = DATA_W'(sa);
              dec_alusel = SEL_SHIFT;
              case (fn)
                FN_SLL:  dec_aluop = OP_SLL;
                FN_SRL:  dec_aluop = OP_SRL;
                default: dec_aluop = OP_SRA;
              endcase
            end
            FN_SYNC: ;
            default: dec_inv = 1'b1;
          endcase
        end
        OPC_ORI, OPC_ANDI, OPC_XORI: begin
          dec_wreg   = 1'b1;
          dec_wd     = rt;
          dec_rd1    = 1'b1;
          dec_imm    = DATA_W'(imm16);
          dec_alusel = SEL_LOGIC;
          case (opc)
            OPC_ORI:  dec_aluop = OP_OR;
            OPC_ANDI: dec_aluop = OP_AND;
            default:  dec_aluop = OP_XOR;
          endcase
        end
        OPC_LUI: begin
          dec_wreg   = 1'b1;
          dec_wd     = rt;
          dec_rd1    = 1'b1;
          dec_imm    = DATA_W'({imm16, 16'h0000});
          dec_alusel = SEL_LOGIC;
          dec_aluop  = OP_OR;
        end
        OPC_PREF: ;
        default: dec_inv = 1'b1;
      endcase
    end
  end

  assign reg1_read_o = dec_rd1;
  assign reg2_read_o = dec_rd2;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  // Operand select: immediate for unread ports, $0 reads zero, then forwarding, then regfile.
  always_comb begin
    fwd1 = fwd_pick(rs, fwd_wreg_i, fwd_load_i, fwd_wd_i, fwd_wdata_i);
    fwd2 = fwd_pick(rt, fwd_wreg_i, fwd_load_i, fwd_wd_i, fwd_wdata_i);
    op1  = reg1_data_i;
    op2  = reg2_data_i;
    if (!dec_rd1)           op1 = dec_imm;
    else if (rs == 5'd0)    op1 = '0;
    else if (fwd1.hit)      op1 = fwd1.data;
    if (!dec_rd2)           op2 = dec_imm;
    else if (rt == 5'd0)    op2 = '0;
    else if (fwd2.hit)      op2 = fwd2.data;
  end

  assign stall    = in_valid && ((dec_rd1 && fwd1.hit && fwd1.load) ||
                                 (dec_rd2 && fwd2.hit && fwd2.load));
  assign in_ready = !stall && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign stall_o  = stall;

  // ID/EX next state: flush beats accept, accept beats drain, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    if (flush_i || (!accept && out_ready)) begin
      valid_d  = 1'b0;
      aluop_d  = OP_NOP;
      alusel_d = SEL_NOP;
      wreg_d   = 1'b0;
      inv_d    = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      pc_d     = pc_i;
      aluop_d  = dec_aluop;
      alusel_d = dec_alusel;
      reg1_d   = op1;
      reg2_d   = op2;
      wd_d     = dec_wd;
      wreg_d   = dec_wreg;
      inv_d    = dec_inv;
      if (dec_inv && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= 32'd0;
      aluop_q  <= OP_NOP;
      alusel_q <= SEL_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wd_q     <= 5'd0;
      wreg_q   <= 1'b0;
      inv_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      inv_q    <= inv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign pc_o      = pc_q;
  assign aluop_o   = aluop_q;
  assign alusel_o  = alusel_q;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;
  assign wd_o      = wd_q;
  assign wreg_o    = wreg_q;
  assign inv_o     = inv_q;
  assign inv_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: table of decode/forwarding vectors plus
// directed sequences for stall, backpressure, flush, counter saturation and reset.
module tb_id_pipe;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned CNT_W   = 8;

  logic                      clk, rst, in_valid, in_ready;
  logic [31:0]               pc_i, inst_i;
  logic                      reg1_read_o, reg2_read_o;
  logic [4:0]                reg1_addr_o, reg2_addr_o;
  logic [DATA_W-1:0]         reg1_data_i, reg2_data_i;
  logic [NUM_FWD-1:0]        fwd_wreg_i, fwd_load_i;
  logic [5*NUM_FWD-1:0]      fwd_wd_i;
  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i;
  logic                      flush_i, out_valid, out_ready;
  logic [31:0]               pc_o;
  logic [7:0]                aluop_o;
  logic [2:0]                alusel_o;
  logic [DATA_W-1:0]         reg1_o, reg2_o;
  logic [4:0]                wd_o;
  logic                      wreg_o, inv_o, stall_o;
  logic [CNT_W-1:0]          inv_cnt_o;

  id_pipe #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_load_i(fwd_load_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .inv_o(inv_o), .stall_o(stall_o), .inv_cnt_o(inv_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtyp(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] ityp(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] r1d, r2d;
    logic [1:0]  fwreg, fload;
    logic [9:0]  fwd;
    logic [63:0] fdata;
    logic        e_rd1, e_rd2;
    logic [7:0]  e_op;
    logic [2:0]  e_sel;
    logic [31:0] e_r1, e_r2;
    logic [4:0]  e_wd;
    logic        e_wreg, e_inv;
  } vec_t;

  function automatic vec_t mkv(input string name, input logic [31:0] inst,
                               input logic [31:0] r1d, input logic [31:0] r2d,
                               input logic [1:0] fwreg, input logic [9:0] fwd,
                               input logic [63:0] fdata,
                               input logic e_rd1, input logic e_rd2,
                               input logic [7:0] e_op, input logic [2:0] e_sel,
                               input logic [31:0] e_r1, input logic [31:0] e_r2,
                               input logic [4:0] e_wd, input logic e_wreg, input logic e_inv);
    vec_t v;
    v.name = name; v.inst = inst; v.r1d = r1d; v.r2d = r2d;
    v.fwreg = fwreg; v.fload = 2'b00; v.fwd = fwd; v.fdata = fdata;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_op = e_op; v.e_sel = e_sel;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_inv = e_inv;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_wreg_i = '0; fwd_load_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".pc"},        pc_o,           32'd0);
    chk({tag, ".aluop"},     32'(aluop_o),   32'd0);
    chk({tag, ".alusel"},    32'(alusel_o),  32'd0);
    chk({tag, ".reg1"},      reg1_o,         32'd0);
    chk({tag, ".reg2"},      reg2_o,         32'd0);
    chk({tag, ".wd"},        32'(wd_o),      32'd0);
    chk({tag, ".wreg"},      32'(wreg_o),    32'd0);
    chk({tag, ".inv"},       32'(inv_o),     32'd0);
    chk({tag, ".inv_cnt"},   32'(inv_cnt_o), 32'd0);
  endtask

  vec_t vecs[$];
  int   cnt_model;

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0; out_ready = 1'b1;
    reg1_data_i = '0; reg2_data_i = '0;
    clear_fwd();
    cnt_model = 0;

    //                name          inst                         r1d           r2d           fwreg  fwd {wd1,wd0}    fdata {d1,d0}                 rd1 rd2 op     sel   r1            r2            wd  wreg inv
    vecs.push_back(mkv("ori",       ityp(6'h0D,0,1,16'h1100),    32'h99,       32'h77,       2'b00, {5'd0,5'd0},     64'h0,                        1, 0, 8'h25, 3'd1, 32'h0,        32'h1100,     1,  1,   0));
    vecs.push_back(mkv("or_fwd",    rtyp(1,1,2,0,6'h25),         32'hDEAD,     32'hDEAD,     2'b01, {5'd0,5'd1},     {32'h0,32'h1100},             1, 1, 8'h25, 3'd1, 32'h1100,     32'h1100,     2,  1,   0));
    vecs.push_back(mkv("or_rf",     rtyp(1,1,2,0,6'h25),         32'h1100,     32'h1100,     2'b00, {5'd0,5'd0},     64'h0,                        1, 1, 8'h25, 3'd1, 32'h1100,     32'h1100,     2,  1,   0));
    vecs.push_back(mkv("and",       rtyp(1,2,3,0,6'h24),         32'hF0F0,     32'h0FF0,     2'b00, {5'd0,5'd0},     64'h0,                        1, 1, 8'h24, 3'd1, 32'hF0F0,     32'h0FF0,     3,  1,   0));
    vecs.push_back(mkv("fwd_prio",  rtyp(3,3,4,0,6'h26),         32'h5,        32'h5,        2'b11, {5'd3,5'd3},     {32'hB,32'hA},                1, 1, 8'h26, 3'd1, 32'hA,        32'hA,        4,  1,   0));
    vecs.push_back(mkv("fwd_old",   rtyp(3,5,4,0,6'h27),         32'h1,        32'h55,       2'b10, {5'd3,5'd0},     {32'hB,32'h0},                1, 1, 8'h27, 3'd1, 32'hB,        32'h55,       4,  1,   0));
    vecs.push_back(mkv("fwd_zero",  rtyp(0,0,6,0,6'h25),         32'h77,       32'h77,       2'b01, {5'd0,5'd0},     {32'h0,32'hFF},               1, 1, 8'h25, 3'd1, 32'h0,        32'h0,        6,  1,   0));
    vecs.push_back(mkv("sll",       rtyp(0,6,5,4,6'h00),         32'h99,       32'h1234,     2'b00, {5'd0,5'd0},     64'h0,                        0, 1, 8'h7C, 3'd2, 32'h4,        32'h1234,     5,  1,   0));
    vecs.push_back(mkv("sra",       rtyp(0,8,7,31,6'h03),        32'h99,       32'h80000000, 2'b00, {5'd0,5'd0},     64'h0,                        0, 1, 8'h03, 3'd2, 32'h1F,       32'h80000000, 7,  1,   0));
    vecs.push_back(mkv("srlv",      rtyp(11,10,9,0,6'h06),       32'h3,        32'hF0,       2'b00, {5'd0,5'd0},     64'h0,                        1, 1, 8'h02, 3'd2, 32'h3,        32'hF0,       9,  1,   0));
    vecs.push_back(mkv("andi",      ityp(6'h0C,3,2,16'h8001),    32'hFFFF0F0F, 32'h0,        2'b00, {5'd0,5'd0},     64'h0,                        1, 0, 8'h24, 3'd1, 32'hFFFF0F0F, 32'h8001,     2,  1,   0));
    vecs.push_back(mkv("xori",      ityp(6'h0E,4,7,16'hFFFF),    32'h1,        32'h0,        2'b00, {5'd0,5'd0},     64'h0,                        1, 0, 8'h26, 3'd1, 32'h1,        32'hFFFF,     7,  1,   0));
    vecs.push_back(mkv("lui",       ityp(6'h0F,0,4,16'hABCD),    32'h55,       32'h0,        2'b00, {5'd0,5'd0},     64'h0,                        1, 0, 8'h25, 3'd1, 32'h0,        32'hABCD0000, 4,  1,   0));
    vecs.push_back(mkv("nop",       32'h0,                       32'h12,       32'h34,       2'b00, {5'd0,5'd0},     64'h0,                        0, 0, 8'h00, 3'd0, 32'h0,        32'h0,        0,  0,   0));
    vecs.push_back(mkv("sync",      rtyp(0,0,0,0,6'h0F),         32'h12,       32'h34,       2'b00, {5'd0,5'd0},     64'h0,                        0, 0, 8'h00, 3'd0, 32'h0,        32'h0,        0,  0,   0));
    vecs.push_back(mkv("pref",      ityp(6'h33,2,3,16'h0010),    32'h12,       32'h34,       2'b00, {5'd0,5'd0},     64'h0,                        0, 0, 8'h00, 3'd0, 32'h0,        32'h0,        0,  0,   0));
    vecs.push_back(mkv("inv_op",    ityp(6'h3F,1,2,16'h0003),    32'h12,       32'h34,       2'b00, {5'd0,5'd0},     64'h0,                        0, 0, 8'h00, 3'd0, 32'h0,        32'h0,        0,  0,   1));
    vecs.push_back(mkv("inv_fn",    rtyp(1,2,3,0,6'h20),         32'h12,       32'h34,       2'b00, {5'd0,5'd0},     64'h0,                        0, 0, 8'h00, 3'd0, 32'h0,        32'h0,        0,  0,   1));
    vecs.push_back(mkv("ld_unread", ityp(6'h0D,1,4,16'h0007),    32'h10,       32'h0,        2'b01, {5'd0,5'd4},     {32'h0,32'h99},               1, 0, 8'h25, 3'd1, 32'h10,       32'h7,        4,  1,   0));
    vecs[vecs.size()-1].fload = 2'b01;

    tick(); tick();
    chk_reset("reset0");
    rst = 1'b0;

    // Table: one instruction per cycle, full throughput.
    for (int i = 0; i < vecs.size(); i++) begin
      inst_i = vecs[i].inst; pc_i = 32'h1000 + 32'(i * 4); in_valid = 1'b1;
      reg1_data_i = vecs[i].r1d; reg2_data_i = vecs[i].r2d;
      fwd_wreg_i = vecs[i].fwreg; fwd_load_i = vecs[i].fload;
      fwd_wd_i = vecs[i].fwd; fwd_wdata_i = vecs[i].fdata;
      #1;
      chk({vecs[i].name, ".rd1"},   32'(reg1_read_o), 32'(vecs[i].e_rd1));
      chk({vecs[i].name, ".rd2"},   32'(reg2_read_o), 32'(vecs[i].e_rd2));
      chk({vecs[i].name, ".a1"},    32'(reg1_addr_o), 32'(vecs[i].inst[25:21]));
      chk({vecs[i].name, ".a2"},    32'(reg2_addr_o), 32'(vecs[i].inst[20:16]));
      chk({vecs[i].name, ".stall"}, 32'(stall_o),     32'd0);
      chk({vecs[i].name, ".ready"}, 32'(in_ready),    32'd1);
      tick();
      if (vecs[i].e_inv) cnt_model++;
      chk({vecs[i].name, ".valid"}, 32'(out_valid),   32'd1);
      chk({vecs[i].name, ".pc"},    pc_o,             32'h1000 + 32'(i * 4));
      chk({vecs[i].name, ".aluop"}, 32'(aluop_o),     32'(vecs[i].e_op));
      chk({vecs[i].name, ".alusel"},32'(alusel_o),    32'(vecs[i].e_sel));
      chk({vecs[i].name, ".reg1"},  reg1_o,           vecs[i].e_r1);
      chk({vecs[i].name, ".reg2"},  reg2_o,           vecs[i].e_r2);
      chk({vecs[i].name, ".wd"},    32'(wd_o),        32'(vecs[i].e_wd));
      chk({vecs[i].name, ".wreg"},  32'(wreg_o),      32'(vecs[i].e_wreg));
      chk({vecs[i].name, ".inv"},   32'(inv_o),       32'(vecs[i].e_inv));
      chk({vecs[i].name, ".cnt"},   32'(inv_cnt_o),   32'(cnt_model));
    end

    // Load-use interlock: OR $5,$4,$0 with a pending load to $4 in EX.
    inst_i = rtyp(4,0,5,0,6'h25); pc_i = 32'h3000; reg1_data_i = 32'h1; reg2_data_i = 32'h2;
    fwd_wreg_i = 2'b01; fwd_load_i = 2'b01; fwd_wd_i = {5'd0,5'd4}; fwd_wdata_i = {32'h0,32'h44};
    #1;
    chk("lu.stall", 32'(stall_o), 32'd1);
    chk("lu.ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu.bubble_valid", 32'(out_valid), 32'd0);
    chk("lu.bubble_wreg",  32'(wreg_o),    32'd0);
    chk("lu.bubble_aluop", 32'(aluop_o),   32'd0);
    chk("lu.bubble_sel",   32'(alusel_o),  32'd0);
    chk("lu.stall_held",   32'(stall_o),   32'd1);
    fwd_load_i = 2'b00;
    #1;
    chk("lu.release_stall", 32'(stall_o), 32'd0);
    chk("lu.release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu.issue_valid", 32'(out_valid), 32'd1);
    chk("lu.issue_pc",    pc_o,           32'h3000);
    chk("lu.issue_reg1",  reg1_o,         32'h44);
    chk("lu.issue_reg2",  reg2_o,         32'h0);
    chk("lu.issue_wd",    32'(wd_o),      32'd5);
    clear_fwd();

    // Backpressure: ANDI $9,$0,0xF0 held for 3 cycles while ORI $10,$0,0xABC waits.
    inst_i = ityp(6'h0C,0,9,16'h00F0); pc_i = 32'h2000;
    tick();
    inst_i = ityp(6'h0D,0,10,16'h0ABC); pc_i = 32'h2004; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp.valid", 32'(out_valid), 32'd1);
      chk("bp.pc",    pc_o,           32'h2000);
      chk("bp.aluop", 32'(aluop_o),   32'h24);
      chk("bp.reg2",  reg2_o,         32'hF0);
      chk("bp.wd",    32'(wd_o),      32'd9);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp.new_pc",    pc_o,         32'h2004);
    chk("bp.new_aluop", 32'(aluop_o), 32'h25);
    chk("bp.new_reg2",  reg2_o,       32'hABC);
    chk("bp.new_wd",    32'(wd_o),    32'd10);

    // Flush with a valid invalid instruction: slot emptied, counter untouched.
    inst_i = 32'hFC000000; pc_i = 32'h4000; flush_i = 1'b1;
    #1;
    chk("fl.ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.wreg",  32'(wreg_o),    32'd0);
    chk("fl.aluop", 32'(aluop_o),   32'd0);
    chk("fl.inv",   32'(inv_o),     32'd0);
    chk("fl.cnt",   32'(inv_cnt_o), 32'(cnt_model));
    flush_i = 1'b0;

    // Counter saturation over 300 reserved-opcode issues.
    for (int n = 0; n < 300; n++) begin
      tick();
      if (cnt_model < 255) cnt_model++;
      chk("sat.valid", 32'(out_valid), 32'd1);
      chk("sat.inv",   32'(inv_o),     32'd1);
      chk("sat.cnt",   32'(inv_cnt_o), 32'(cnt_model));
    end
    chk("sat.final", 32'(inv_cnt_o), 32'd255);

    // Reset under backpressure drops the held SLL and the waiting instruction.
    inst_i = rtyp(0,6,5,4,6'h00); pc_i = 32'h5000; reg2_data_i = 32'h6666;
    tick();
    chk("rbp.sll_reg1", reg1_o,          32'h4);
    chk("rbp.sll_reg2", reg2_o,          32'h6666);
    chk("rbp.sll_sel",  32'(alusel_o),   32'd2);
    out_ready = 1'b0; inst_i = ityp(6'h0D,0,1,16'h1234); pc_i = 32'h5004; rst = 1'b1;
    tick();
    chk_reset("rbp");
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rbp.after_valid", 32'(out_valid), 32'd0);
    chk("rbp.after_pc",    pc_o,           32'd0);
    chk("rbp.after_wreg",  32'(wreg_o),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
